// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// master = byte producer, slave = uart_tx.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;
  logic       tx_busy;

  modport master (output tx_data, tx_data_valid, input  tx_data_ready, tx_busy);
  modport slave  (input  tx_data, tx_data_valid, output tx_data_ready, tx_busy);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, LSB first, 1 or 2 stop bits.
// Optional parity bit after bit 7 when the macro UART_TX_PARITY_EN is defined
// (PARITY_ODD selects odd parity); without it the parity path is not built.
module uart_tx #(
  parameter int CLK_FRE    = 50,
  parameter int BAUD_RATE  = 115200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_tx_if.slave   bus,
  output logic       tx_pin
);

  localparam int          CYCLE     = CLK_FRE * 1000000 / BAUD_RATE;
  localparam logic [15:0] CYC_LAST  = 16'(CYCLE - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  // Reject configurations the counters cannot represent.
  if (CYCLE < 2 || CYCLE > 65535 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: illegal CYCLE/STOP_BITS/PARITY_ODD");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q,   cnt_d;    // clocks into the current bit
  logic [2:0]  bit_q,   bit_d;    // data bit index, reused as stop bit index
  logic [7:0]  shift_q, shift_d;  // latched byte, kept intact for parity
  logic        pin_q,   pin_d;
  logic        bit_end;

  assign bit_end = (cnt_q == CYC_LAST);

  // Next-state: each bit boundary picks the next line level so tx_pin and state move together.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pin_d   = pin_q;
    case (state_q)
      S_IDLE: begin
        pin_d = 1'b1;
        cnt_d = '0;
        if (bus.tx_data_valid) begin
          shift_d = bus.tx_data;
          pin_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d = cnt_q + 16'd1;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          pin_d   = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            pin_d   = (^shift_q) ^ 1'(PARITY_ODD);
            state_d = S_PARITY;
`else
            pin_d   = 1'b1;
            bit_d   = '0;
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            pin_d = shift_q[bit_q + 3'd1];
          end
        end
      end
      S_PARITY: begin
        cnt_d = cnt_q + 16'd1;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          pin_d   = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + 16'd1;
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == STOP_LAST) state_d = S_IDLE;
          else                    bit_d   = bit_q + 3'd1;
        end
      end
      default: begin
        pin_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any frame and parks the line high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      pin_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pin_q   <= pin_d;
    end
  end

  assign bus.tx_data_ready = (state_q == S_IDLE);
  assign bus.tx_busy       = (state_q != S_IDLE);
  assign tx_pin            = pin_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (1 stop even, 1 stop odd, 2 stop even) driven
// with the same stimulus, checked every cycle against a frame-level line model,
// plus literal expectations on decoded bytes and timing.
module tb_uart_tx;
  localparam int CYC = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic [2:0] pin;
  logic [2:0] rdy;
  logic [2:0] busy;

  uart_tx_if ifa ();
  uart_tx_if ifb ();
  uart_tx_if ifc ();
  assign ifa.tx_data = data; assign ifa.tx_data_valid = valid;
  assign ifb.tx_data = data; assign ifb.tx_data_valid = valid;
  assign ifc.tx_data = data; assign ifc.tx_data_valid = valid;
  assign rdy  = {ifc.tx_data_ready, ifb.tx_data_ready, ifa.tx_data_ready};
  assign busy = {ifc.tx_busy, ifb.tx_busy, ifa.tx_busy};

  uart_tx #(.CLK_FRE(1), .BAUD_RATE(100000), .STOP_BITS(1), .PARITY_ODD(0))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave), .tx_pin(pin[0]));
  uart_tx #(.CLK_FRE(1), .BAUD_RATE(100000), .STOP_BITS(1), .PARITY_ODD(1))
    u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave), .tx_pin(pin[1]));
  uart_tx #(.CLK_FRE(1), .BAUD_RATE(100000), .STOP_BITS(2), .PARITY_ODD(0))
    u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave), .tx_pin(pin[2]));

  always #5 clk = ~clk;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic pin_h [3][4096];
  logic rdy_h [3][4096];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Frame model: on accept, build the list of bit levels and walk it CYC clocks per bit.
  logic [11:0] fb [3];
  int          nb [3];
  int          pos [3];
  bit          act [3];
  bit          started = 1'b0;

  function automatic int stop_of(input int i); return (i == 2) ? 2 : 1; endfunction
  function automatic int podd_of(input int i); return (i == 1) ? 1 : 0; endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) act[i] = 1'b0;
      else if (act[i]) begin
        pos[i]++;
        if (pos[i] == nb[i] * CYC) act[i] = 1'b0;
      end else if (valid) begin
        int n;
        fb[i] = '0;
        n = 1;                               // bit 0 = start bit (0)
        for (int b = 0; b < 8; b++) begin fb[i][n] = data[b]; n++; end
        if (P == 1) begin fb[i][n] = (^data) ^ (podd_of(i) == 1); n++; end
        for (int s = 0; s < stop_of(i); s++) begin fb[i][n] = 1'b1; n++; end
        nb[i]  = n;
        pos[i] = 0;
        act[i] = 1'b1;
      end
    end
    if (!rst_n) started = 1'b1;
  end

  // Record history and compare every instance against the model, away from the edge.
  initial forever begin
    @(negedge clk);
    if (cyc < 4096)
      for (int i = 0; i < 3; i++) begin
        pin_h[i][cyc] = pin[i];
        rdy_h[i][cyc] = rdy[i];
      end
    if (started)
      for (int i = 0; i < 3; i++) begin
        logic ep;
        ep = act[i] ? fb[i][pos[i] / CYC] : 1'b1;
        chk($sformatf("model_pin%0d", i),  pin[i],  ep);
        chk($sformatf("model_rdy%0d", i),  rdy[i],  !act[i]);
        chk($sformatf("model_busy%0d", i), busy[i], act[i]);
      end
  end

  task automatic tick(); @(posedge clk); #2; endtask
  task automatic idle(input int n); repeat (n) tick(); endtask
  task automatic send(input logic [7:0] d, output int acc);
    data = d; valid = 1'b1; tick(); acc = cyc; valid = 1'b0;
  endtask

  function automatic logic [7:0] decode(input int i, input int acc);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = pin_h[i][acc + CYC * (b + 1) + 5];
    return r;
  endfunction

  initial begin
    int acc, acc2, n, m;
    bit found;
    logic [9:0] pat;

    // Power-up reset, idle, then reset again mid-idle for 3 clocks.
    idle(2); rst_n = 1'b1; idle(5);
    rst_n = 1'b0; idle(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_pin%0d", i),  pin[i],  1'b1);
      chk($sformatf("rst_rdy%0d", i),  rdy[i],  1'b1);
      chk($sformatf("rst_busy%0d", i), busy[i], 1'b0);
    end
    rst_n = 1'b1; idle(3);

    // 0x55: start, 1010..., stop, checked mid-bit.
    send(8'h55, acc); idle(140);
    pat = 10'b10_1010_1010;
    chk("t2_first_low", pin_h[0][acc], 1'b0);
    for (int b = 0; b < 9; b++) chk($sformatf("t2_bit%0d", b), pin_h[0][acc + CYC * b + 5], pat[b]);
    chk("t2_rdy_before", rdy_h[0][acc + 99 + CYC * P], 1'b0);
    chk("t2_rdy_rise",   rdy_h[0][acc + 100 + CYC * P], 1'b1);

    // Valid held high: 0xA5 then 0x3C back to back.
    data = 8'hA5; valid = 1'b1; tick(); acc = cyc; data = 8'h3C;
    found = 1'b0; acc2 = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ifa.tx_data_ready) begin tick(); acc2 = cyc; found = 1'b1; break; end
    end
    valid = 1'b0;
    chk("t3_second_accept", found, 1'b1);
    idle(300);
    chk("t3_spacing", acc2 - acc, 101 + CYC * P);
    chk("t3_byte0_a", decode(0, acc), 8'hA5);
    chk("t3_byte1_a", decode(0, acc2), 8'h3C);
    chk("t3_byte1_b", decode(1, acc2), 8'h3C);
    chk("t3_byte0_c", decode(2, acc), 8'hA5);

`ifdef UART_TX_PARITY_EN
    // Parity of 0x07: even -> 1, odd -> 0; frame 110 clocks.
    send(8'h07, acc); idle(150);
    chk("t4_par_even", pin_h[0][acc + 95], 1'b1);
    chk("t4_par_odd",  pin_h[1][acc + 95], 1'b0);
    chk("t4_rdy_before", rdy_h[0][acc + 109], 1'b0);
    chk("t4_rdy_rise",   rdy_h[0][acc + 110], 1'b1);
    chk("t4_byte", decode(0, acc), 8'h07);
`endif

    // Reset during data bit 4 of 0xF0, then a clean 0x81.
    send(8'hF0, acc);
    while (cyc < acc + 54) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t5_bit3_low",  pin_h[0][acc + 45], 1'b0);
    chk("t5_pin_after", pin[0], 1'b1);
    chk("t5_rdy_after", rdy[0], 1'b1);
    chk("t5_rdy_c",     rdy[2], 1'b1);
    idle(5);
    send(8'h81, acc); idle(140);
    chk("t5_byte_a", decode(0, acc), 8'h81);
    chk("t5_byte_c", decode(2, acc), 8'h81);

    // Two stop bits, 0x00: 90 low then 20 high (plus a zero parity bit if enabled).
    send(8'h00, acc); idle(150);
    n = 0; while (n < 200 && pin_h[2][acc + n] == 1'b0) n++;
    m = 0; while (m < 200 && pin_h[2][acc + n + m] == 1'b1 && rdy_h[2][acc + n + m] == 1'b0) m++;
    chk("t6_low_run",  n, 90 + CYC * P);
    chk("t6_high_run", m, 20);
    chk("t6_rdy_before", rdy_h[2][acc + 109 + CYC * P], 1'b0);
    chk("t6_rdy_rise",   rdy_h[2][acc + 110 + CYC * P], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
